// File: rtl/ysyx_25060170_stage_ctrl_pkg.sv
// Shared definitions for the ysyx_25060170 multi-cycle stage controller.
//   stage_e        : FSM state encoding. It is visible on the debug "state" port,
//                    so the numeric values are fixed.
//   TimeoutDefault : default number of MEM wait cycles allowed before the controller
//                    gives up and enters ERR.
package ysyx_25060170_stage_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6,
      StErr    = 3'd7
   } stage_e;

   localparam int unsigned TimeoutDefault = 16;

endpackage

// File: rtl/ysyx_25060170_stage_ctrl.sv
// Multi-cycle stage controller: sequences fetch / decode / execute / memory /
// write-back for a single-issue core, counts retired instructions and traps on
// ebreak (HALT) or on a load/store timeout (ERR). HALT and ERR are absorbing
// until rst is asserted.
//
// Ports
//   clk, rst       : core clock (rising edge); synchronous active-high reset
//   if_req         : fetch request, high in FETCH
//   if_resp_valid  : fetched instruction available this cycle
//   ir_we          : instruction-register load (FETCH and if_resp_valid)
//   id_valid       : decoded operands valid to the EXU (EXEC)
//   ex_res_we      : load the EXU result into the EX/LS register (EXEC)
//   is_mem         : decoded instruction is a load/store (sampled in EXEC)
//   is_ebreak      : decoded instruction is ebreak (sampled in EXEC)
//   branch_taken   : next PC is the jump/branch target (used in WB)
//   ls_req         : load/store request, high in MEM
//   ls_resp_valid  : load/store complete this cycle
//   rf_we_en       : register-file write commit (WB)
//   pc_we, pc_sel  : PC update enable (WB); 0 selects PC+4, 1 selects the target
//   halt, err      : sticky trap flags (state HALT / ERR)
//   state          : current FSM state, for debug
//   retire_cnt     : retired-instruction count; wraps at 2^32
module ysyx_25060170_stage_ctrl
   import ysyx_25060170_stage_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic        clk,
   input  logic        rst,
   output logic        if_req,
   input  logic        if_resp_valid,
   output logic        ir_we,
   output logic        id_valid,
   output logic        ex_res_we,
   input  logic        is_mem,
   input  logic        is_ebreak,
   input  logic        branch_taken,
   output logic        ls_req,
   input  logic        ls_resp_valid,
   output logic        rf_we_en,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        halt,
   output logic        err,
   output logic [2:0]  state,
   output logic [31:0] retire_cnt
);

   // The counter only has to count up to TIMEOUT-1.
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   stage_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     retire_q, retire_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      retire_d = retire_q;
      case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  if (if_resp_valid) state_d = StDecode;
         StDecode: state_d = StExec;
         StExec: begin
            // ebreak wins over a load/store; it retires but never writes the PC.
            if (is_ebreak) begin
               state_d  = StHalt;
               retire_d = retire_q + 32'd1;
            end else if (is_mem) begin
               state_d = StMem;
               cnt_d   = '0;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            // A response in the last allowed cycle still completes normally.
            if (ls_resp_valid) begin
               state_d = StWb;
            end else if (cnt_q == CntLast) begin
               state_d = StErr;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWb: begin
            state_d  = StFetch;
            retire_d = retire_q + 32'd1;
         end
         StHalt:  state_d = StHalt;
         StErr:   state_d = StErr;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         retire_q <= retire_d;
      end
   end

   // Everything except ir_we (and the pc_sel pass-through) decodes the
   // registered state only.
   assign if_req     = (state_q == StFetch);
   assign ir_we      = (state_q == StFetch) & if_resp_valid;
   assign id_valid   = (state_q == StExec);
   assign ex_res_we  = (state_q == StExec);
   assign ls_req     = (state_q == StMem);
   assign rf_we_en   = (state_q == StWb);
   assign pc_we      = (state_q == StWb);
   assign pc_sel     = (state_q == StWb) & branch_taken;
   assign halt       = (state_q == StHalt);
   assign err        = (state_q == StErr);
   assign state      = state_q;
   assign retire_cnt = retire_q;

endmodule

// File: doc/ysyx_25060170_stage_ctrl.md
YSYX_25060170_STAGE_CTRL -- requirements
Module: ysyx_25060170_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum MEM-state wait cycles before error.
REQ-002 SHALL have port clk  input  1  core clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req  output  1  fetch request, held while in FETCH.
REQ-005 SHALL have port if_resp_valid  input  1  fetched instruction available this cycle.
REQ-006 SHALL have port ir_we  output  1  instruction-register load enable.
REQ-007 SHALL have port id_valid  output  1  decoded operands valid to EXU.
REQ-008 SHALL have port ex_res_we  output  1  load EXU result into EX/LS register.
REQ-009 SHALL have port is_mem  input  1  decoded instruction is load/store.
REQ-010 SHALL have port is_ebreak  input  1  decoded instruction is ebreak.
REQ-011 SHALL have port branch_taken  input  1  next PC is jump/branch target.
REQ-012 SHALL have port ls_req  output  1  load/store request, held while in MEM.
REQ-013 SHALL have port ls_resp_valid  input  1  load/store complete this cycle.
REQ-014 SHALL have port rf_we_en  output  1  register-file write commit enable.
REQ-015 SHALL have port pc_we  output  1  PC update enable.
REQ-016 SHALL have port pc_sel  output  1  0 = PC+4, 1 = target.
REQ-017 SHALL have port halt  output  1  sticky, ebreak reached.
REQ-018 SHALL have port err  output  1  sticky, load/store timeout.
REQ-019 SHALL have port state  output  3  current FSM state, debug.
REQ-020 SHALL have port retire_cnt  output  32  retired-instruction count.

Function
REQ-021 SHALL implement the FSM states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
REQ-022 SHALL transition IDLE->FETCH unconditionally after one cycle.
REQ-023 SHALL, in FETCH, assert if_req; on if_resp_valid, assert ir_we combinationally in the same cycle and go to DECODE, else stay in FETCH.
REQ-024 SHALL, in DECODE, spend exactly one cycle and go to EXEC.
REQ-025 SHALL, in EXEC, assert id_valid and ex_res_we for one cycle, sampling is_ebreak/is_mem in that cycle only.
REQ-026 SHALL, in EXEC, apply the priority is_ebreak -> HALT (retire_cnt+1, pc_we=0), then is_mem -> MEM, else -> WB.
REQ-027 SHALL, in MEM, assert ls_req; on ls_resp_valid go to WB.
REQ-028 SHALL, in MEM, clear the timeout counter on MEM entry, and on each MEM cycle without a response either go to ERR (counter == TIMEOUT-1) or increment the counter.
REQ-029 SHALL give ls_resp_valid priority over timeout in the same cycle.
REQ-030 SHALL, in WB, assert rf_we_en and pc_we for one cycle, drive pc_sel=branch_taken, increment retire_cnt, and go to FETCH.
REQ-031 SHALL let retire_cnt wrap from 0xFFFFFFFF to 0.
REQ-032 SHALL make HALT and ERR absorbing until rst, with halt=1 in HALT, err=1 in ERR, and all other outputs 0.
REQ-033 SHALL ignore if_resp_valid outside FETCH and ls_resp_valid outside MEM.
REQ-034 SHALL never assert if_req and ls_req in the same cycle.
REQ-035 SHALL drive all outputs except ir_we as decodes of the registered state.

Reset
REQ-036 SHALL, while rst=1 at a clock edge, load state=IDLE, clear retire_cnt, the timeout counter, halt and err, and force all outputs to 0.
REQ-037 SHALL let a reset asserted in any state, including mid-MEM or in HALT/ERR, abort the operation; the next state is IDLE with no retire.

Structure
REQ-038 SHALL place the state encodings and the TIMEOUT default in the shared define file alongside the existing ysyx_25060170 macros.
REQ-039 SHALL keep the timeout counter inline; no sub-module is needed, target 120-250 RTL lines.

Verification
REQ-040 SHALL cover ALU op: release rst; if_resp_valid on the 2nd FETCH cycle; is_mem=0; branch_taken=0 -> state sequence 0,1,1,2,3,5,1; rf_we_en=1 and pc_we=1 with pc_sel=0 only in WB; retire_cnt=1.
REQ-041 SHALL cover a load with a 3-cycle wait: is_mem=1, ls_resp_valid on the 3rd MEM cycle -> ls_req high for 3 cycles, then WB, retire_cnt+1.
REQ-042 SHALL cover timeout: TIMEOUT=4, is_mem=1, no response -> exactly 4 ls_req cycles, then ERR with err=1 held for 10 cycles until rst; ls_resp_valid arriving on the 4th cycle instead -> WB.
REQ-043 SHALL cover ebreak: is_ebreak=1 and is_mem=1 together in EXEC -> HALT, halt=1, retire_cnt+1, no ls_req, pc_we=0; further if_resp_valid is ignored.
REQ-044 SHALL cover reset mid-MEM: rst for 1 cycle on the 2nd MEM cycle -> state=IDLE, retire_cnt=0, ls_req=0 the next cycle.
REQ-045 SHALL cover wrap: preload retire_cnt=0xFFFFFFFF via force and run one WB -> retire_cnt=0.
